// File: rtl/forthsuper_pkg.sv
// Shared Forth-core types: memory-stack bus ops, data-stack commands and
// the data-stack controller state encoding.
package forthsuper_pkg;

  typedef enum logic [1:0] {
    SS_NOP  = 2'd0,
    SS_PUSH = 2'd1,
    SS_POP  = 2'd2,
    SS_PICK = 2'd3
  } stack_ops;

  typedef enum logic [2:0] {
    DS_NOP  = 3'd0,
    DS_LIT  = 3'd1,
    DS_DUP  = 3'd2,
    DS_DROP = 3'd3,
    DS_SWAP = 3'd4,
    DS_OVER = 3'd5,
    DS_ROT  = 3'd6,
    DS_NIP  = 3'd7
  } ds_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ROT2 = 1'b1
  } ds_state_t;

  // Commands that grow the stack by one entry.
  function automatic logic is_push(input ds_op_t op);
    return (op == DS_LIT) || (op == DS_DUP) || (op == DS_OVER);
  endfunction

endpackage

// File: rtl/ds_ctrl.sv
// Data-stack controller: caches TOS/NOS in flops and spills/fills the rest
// through the memory-stack bus. Optional macro DS_CTRL_HWM_EN adds output hwm.
module ds_ctrl
  import forthsuper_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int DSZ   = 32,
  parameter int CAP   = DEPTH + 1,
  parameter int DPW   = $clog2(CAP + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  ds_op_t         cmd_op,
  input  logic [DSZ-1:0] cmd_vi,
  output logic [DSZ-1:0] tos,
  output logic [DSZ-1:0] nos,
  output logic [DPW-1:0] depth,
  output logic           err_ovf,
  output logic           err_udf,
  output stack_ops       ss_op,
  output logic [DSZ-1:0] ss_vi,
  input  logic [DSZ-1:0] ss_s
`ifdef DS_CTRL_HWM_EN
  ,
  output logic [DPW-1:0] hwm
`endif
);

  localparam logic [DPW-1:0] CAP_D = DPW'(CAP);

  ds_state_t      state, state_d;
  logic [DSZ-1:0] t, t_d, n, n_d, tmp, tmp_d;
  logic [DPW-1:0] depth_d;
  logic           udf_d, ovf_d, accept, spill, fill;

  function automatic logic [DPW-1:0] min_depth(input ds_op_t op);
    case (op)
      DS_DUP, DS_DROP:           return DPW'(1);
      DS_OVER, DS_NIP, DS_SWAP:  return DPW'(2);
      DS_ROT:                    return DPW'(3);
      default:                   return '0;
    endcase
  endfunction

  // Ready is held low while reset is asserted so no bus op leaks out.
  assign cmd_ready = (state == ST_IDLE) && rst;
  assign accept    = cmd_valid && cmd_ready;
  assign tos       = t;
  assign nos       = n;

  always_comb begin
    state_d = state;
    t_d     = t;
    n_d     = n;
    tmp_d   = tmp;
    depth_d = depth;
    udf_d   = 1'b0;
    ovf_d   = 1'b0;
    spill   = 1'b0;
    fill    = 1'b0;
    ss_op   = SS_NOP;
    ss_vi   = '0;
    if (state == ST_ROT2) begin
      ss_op   = SS_PUSH;
      ss_vi   = tmp;
      state_d = ST_IDLE;
    end else if (accept) begin
      if (depth < min_depth(cmd_op)) begin
        udf_d = 1'b1;
      end else if (is_push(cmd_op) && depth == CAP_D) begin
        ovf_d = 1'b1;
      end else begin
        case (cmd_op)
          DS_LIT:  begin spill = 1'b1; n_d = t; t_d = cmd_vi; depth_d = depth + DPW'(1); end
          DS_DUP:  begin spill = 1'b1; n_d = t; depth_d = depth + DPW'(1); end
          DS_OVER: begin spill = 1'b1; n_d = t; t_d = n; depth_d = depth + DPW'(1); end
          DS_DROP: begin fill = 1'b1; t_d = n; depth_d = depth - DPW'(1); end
          DS_NIP:  begin fill = 1'b1; depth_d = depth - DPW'(1); end
          DS_SWAP: begin t_d = n; n_d = t; end
          DS_ROT: begin
            // a b c -> b c a: pop a into t now, push b back next cycle.
            ss_op   = SS_POP;
            tmp_d   = n;
            n_d     = t;
            t_d     = ss_s;
            state_d = ST_ROT2;
          end
          default: ;
        endcase
      end
      if (spill && depth >= DPW'(2)) begin
        ss_op = SS_PUSH;
        ss_vi = n;
      end
      if (fill) begin
        if (depth >= DPW'(3)) begin
          ss_op = SS_POP;
          n_d   = ss_s;
        end else begin
          n_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      t       <= '0;
      n       <= '0;
      depth   <= '0;
      err_udf <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      state   <= state_d;
      t       <= t_d;
      n       <= n_d;
      depth   <= depth_d;
      err_udf <= udf_d;
      err_ovf <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    tmp <= tmp_d;
  end

`ifdef DS_CTRL_HWM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hwm <= '0;
    end else if (depth > hwm) begin
      hwm <= depth;
    end
  end
`endif

endmodule

// File: tb/tb_ds_ctrl.sv
// Directed bench for ds_ctrl with a behavioural memory stack on the bus.
module tb_ds_ctrl;
  import forthsuper_pkg::*;

  localparam int DSZ = 32;
  localparam int DPW = 7;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  ds_op_t         cmd_op = DS_NOP;
  logic [DSZ-1:0] cmd_vi = '0;
  logic [DSZ-1:0] tos, nos, ss_vi, ss_s;
  logic [DPW-1:0] depth;
  logic           err_ovf, err_udf;
  stack_ops       ss_op;
`ifdef DS_CTRL_HWM_EN
  logic [DPW-1:0] hwm;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  stack_ops       cap_op;
  logic [DSZ-1:0] cap_vi;
  logic           cap_ready;

  // Memory stack model: top visible combinationally after each op.
  logic [DSZ-1:0] smem [0:63];
  logic [6:0]     sp;
  logic [5:0]     top_idx;

  assign top_idx = sp[5:0] - 6'd1;
  always_comb ss_s = (sp != 7'd0) ? smem[top_idx] : '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp <= 7'd0;
    end else if (ss_op == SS_PUSH) begin
      smem[sp[5:0]] <= ss_vi;
      sp <= sp + 7'd1;
    end else if (ss_op == SS_POP) begin
      sp <= sp - 7'd1;
    end
  end

  always #5 clk = ~clk;

  ds_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_vi(cmd_vi), .tos(tos), .nos(nos), .depth(depth),
    .err_ovf(err_ovf), .err_udf(err_udf), .ss_op(ss_op), .ss_vi(ss_vi),
    .ss_s(ss_s)
`ifdef DS_CTRL_HWM_EN
    , .hwm(hwm)
`endif
  );

  // Offers one command for one cycle; starts and ends at posedge+1.
  task automatic issue(input ds_op_t op, input logic [DSZ-1:0] vi);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_vi    = vi;
    @(negedge clk);
    cap_op    = ss_op;
    cap_vi    = ss_vi;
    cap_ready = cmd_ready;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = DS_NOP;
    cmd_vi    = '0;
  endtask

  task automatic test_reset();
    cmd_valid = 1'b1;
    cmd_op    = DS_LIT;
    cmd_vi    = 32'h55;
    #12;
    n_checks++;
    if (ss_op !== SS_NOP) begin n_fail++; $display("FAIL reset_ss_op: got %0d want 0", ss_op); end
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    issue(DS_LIT, 32'd1);
    issue(DS_LIT, 32'd2);
    issue(DS_LIT, 32'd3);
    rst = 1'b0;
    #1;
    n_checks++;
    if (tos !== '0 || nos !== '0 || depth !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got tos=%0h nos=%0h depth=%0d want 0 0 0", tos, nos, depth);
    end
    n_checks++;
    if (ss_op !== SS_NOP || err_udf !== 1'b0 || err_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ss_op=%0d udf=%b ovf=%b want 0 0 0", ss_op, err_udf, err_ovf);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_lit_drop();
    int pops;
    issue(DS_LIT, 32'd1);
    issue(DS_LIT, 32'd2);
    n_checks++;
    if (cap_op !== SS_NOP) begin n_fail++; $display("FAIL lit2_bus: got %0d want 0", cap_op); end
    issue(DS_LIT, 32'd3);
    n_checks++;
    if (cap_op !== SS_PUSH || cap_vi !== 32'd1) begin
      n_fail++; $display("FAIL lit3_spill: got op=%0d vi=%0h want 1 1", cap_op, cap_vi);
    end
    issue(DS_LIT, 32'd4);
    n_checks++;
    if (cap_op !== SS_PUSH || cap_vi !== 32'd2) begin
      n_fail++; $display("FAIL lit4_spill: got op=%0d vi=%0h want 1 2", cap_op, cap_vi);
    end
    n_checks++;
    if (tos !== 32'd4 || nos !== 32'd3 || depth !== 7'd4) begin
      n_fail++; $display("FAIL lit_state: got tos=%0h nos=%0h depth=%0d want 4 3 4", tos, nos, depth);
    end
    pops = 0;
    for (int i = 0; i < 3; i++) begin
      issue(DS_DROP, '0);
      if (cap_op == SS_POP) pops++;
    end
    n_checks++;
    if (pops !== 2) begin n_fail++; $display("FAIL drop_pops: got %0d want 2", pops); end
    n_checks++;
    if (tos !== 32'd1 || nos !== 32'd0 || depth !== 7'd1) begin
      n_fail++; $display("FAIL drop_state: got tos=%0h nos=%0h depth=%0d want 1 0 1", tos, nos, depth);
    end
    issue(DS_DROP, '0);
    n_checks++;
    if (depth !== 7'd0 || sp !== 7'd0) begin
      n_fail++; $display("FAIL drop_empty: got depth=%0d sp=%0d want 0 0", depth, sp);
    end
  endtask

  task automatic test_rot();
    issue(DS_LIT, 32'd10);
    issue(DS_LIT, 32'd20);
    issue(DS_LIT, 32'd30);
    issue(DS_ROT, '0);
    n_checks++;
    if (cap_op !== SS_POP) begin n_fail++; $display("FAIL rot_pop: got %0d want 2", cap_op); end
    n_checks++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rot_ready_low: got %b want 0", cmd_ready); end
    n_checks++;
    if (tos !== 32'd10 || nos !== 32'd30 || depth !== 7'd3) begin
      n_fail++; $display("FAIL rot_state: got tos=%0d nos=%0d depth=%0d want 10 30 3", tos, nos, depth);
    end
    @(negedge clk);
    n_checks++;
    if (ss_op !== SS_PUSH || ss_vi !== 32'd20) begin
      n_fail++; $display("FAIL rot_push: got op=%0d vi=%0d want 1 20", ss_op, ss_vi);
    end
    @(posedge clk); #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || ss_s !== 32'd20 || sp !== 7'd1) begin
      n_fail++; $display("FAIL rot_mem: got ready=%b top=%0d sp=%0d want 1 20 1", cmd_ready, ss_s, sp);
    end
    for (int i = 0; i < 3; i++) issue(DS_DROP, '0);
  endtask

  task automatic test_underflow();
    issue(DS_LIT, 32'd7);
    issue(DS_SWAP, '0);
    n_checks++;
    if (cap_op !== SS_NOP || cap_ready !== 1'b1) begin
      n_fail++; $display("FAIL udf_bus: got op=%0d ready=%b want 0 1", cap_op, cap_ready);
    end
    n_checks++;
    if (err_udf !== 1'b1 || err_ovf !== 1'b0 || tos !== 32'd7 || depth !== 7'd1) begin
      n_fail++;
      $display("FAIL udf_swap: got udf=%b ovf=%b tos=%0d depth=%0d want 1 0 7 1", err_udf, err_ovf, tos, depth);
    end
    @(posedge clk); #1;
    n_checks++;
    if (err_udf !== 1'b0) begin n_fail++; $display("FAIL udf_pulse: got %b want 0", err_udf); end
    issue(DS_DROP, '0);
    issue(DS_DROP, '0);
    n_checks++;
    if (err_udf !== 1'b1 || depth !== 7'd0) begin
      n_fail++; $display("FAIL udf_drop: got udf=%b depth=%0d want 1 0", err_udf, depth);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 65; i++) issue(DS_LIT, 32'(100 + i));
    n_checks++;
    if (depth !== 7'd65 || sp !== 7'd63) begin
      n_fail++; $display("FAIL ovf_fill: got depth=%0d sp=%0d want 65 63", depth, sp);
    end
    issue(DS_LIT, 32'hDEAD);
    n_checks++;
    if (cap_op !== SS_NOP) begin n_fail++; $display("FAIL ovf_bus: got %0d want 0", cap_op); end
    n_checks++;
    if (err_ovf !== 1'b1 || err_udf !== 1'b0 || depth !== 7'd65 || tos !== 32'd164) begin
      n_fail++;
      $display("FAIL ovf_lit: got ovf=%b udf=%b depth=%0d tos=%0d want 1 0 65 164", err_ovf, err_udf, depth, tos);
    end
    @(posedge clk); #1;
    n_checks++;
    if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_pulse: got %b want 0", err_ovf); end
    for (int j = 1; j <= 65; j++) begin
      issue(DS_DROP, '0);
      if (j < 65) begin
        n_checks++;
        if (tos !== 32'(164 - j)) begin
          n_fail++; $display("FAIL ovf_drain_%0d: got tos=%0d want %0d", j, tos, 164 - j);
        end
      end
    end
    n_checks++;
    if (depth !== 7'd0 || sp !== 7'd0) begin
      n_fail++; $display("FAIL ovf_empty: got depth=%0d sp=%0d want 0 0", depth, sp);
    end
  endtask

  typedef struct { ds_op_t op; logic [DSZ-1:0] vi; } vec_t;

  task automatic test_back_to_back();
    vec_t v [17];
    logic [DSZ-1:0] q [$];
    logic [DSZ-1:0] tmpv;
    v = '{'{DS_LIT, 32'd5}, '{DS_LIT, 32'd6}, '{DS_OVER, 0}, '{DS_DUP, 0},
          '{DS_LIT, 32'd7}, '{DS_OVER, 0}, '{DS_NIP, 0}, '{DS_SWAP, 0},
          '{DS_NIP, 0}, '{DS_DROP, 0}, '{DS_OVER, 0}, '{DS_DUP, 0},
          '{DS_NIP, 0}, '{DS_NIP, 0}, '{DS_DROP, 0}, '{DS_DROP, 0}, '{DS_DROP, 0}};
    for (int k = 0; k < 17; k++) begin
      case (v[k].op)
        DS_LIT:  q.push_front(v[k].vi);
        DS_DUP:  q.push_front(q[0]);
        DS_OVER: q.push_front(q[1]);
        DS_NIP:  q.delete(1);
        DS_DROP: tmpv = q.pop_front();
        DS_SWAP: begin tmpv = q[0]; q[0] = q[1]; q[1] = tmpv; end
        default: ;
      endcase
      issue(v[k].op, v[k].vi);
      n_checks++;
      if (depth !== 7'(q.size()) || err_udf !== 1'b0 || err_ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_depth_%0d: got depth=%0d udf=%b ovf=%b want %0d 0 0", k, depth, err_udf, err_ovf, q.size());
      end
      if (q.size() >= 1) begin
        n_checks++;
        if (tos !== q[0]) begin n_fail++; $display("FAIL b2b_tos_%0d: got %0d want %0d", k, tos, q[0]); end
      end
      if (q.size() >= 2) begin
        n_checks++;
        if (nos !== q[1]) begin n_fail++; $display("FAIL b2b_nos_%0d: got %0d want %0d", k, nos, q[1]); end
      end
      if (q.size() >= 3) begin
        n_checks++;
        if (ss_s !== q[2]) begin n_fail++; $display("FAIL b2b_mem_%0d: got %0d want %0d", k, ss_s, q[2]); end
      end
    end
  endtask

`ifdef DS_CTRL_HWM_EN
  task automatic test_hwm();
    rst = 1'b0;
    #3;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (hwm !== 7'd0) begin n_fail++; $display("FAIL hwm_reset: got %0d want 0", hwm); end
    for (int i = 0; i < 5; i++) issue(DS_LIT, 32'(i + 1));
    for (int i = 0; i < 3; i++) issue(DS_DROP, '0);
    n_checks++;
    if (hwm !== 7'd5 || depth !== 7'd2) begin
      n_fail++; $display("FAIL hwm_peak: got hwm=%0d depth=%0d want 5 2", hwm, depth);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lit_drop();
    test_rot();
    test_underflow();
    test_overflow();
    test_back_to_back();
`ifdef DS_CTRL_HWM_EN
    test_hwm();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ds_ctrl.md
Name: ds_ctrl

Overview:
- Data-stack controller: the initiating end of the 32-bit stack bus. It sits between the Forth execution unit and the EBR-backed stack module.
- Caches TOS (t) and NOS (n) in flops and spills deeper entries to the memory stack with PUSH/POP bus ops.
- Translates Forth stack primitives (LIT, DUP, DROP, SWAP, OVER, ROT, NIP) into bus ops and tracks depth.
- Flags overflow and underflow.

Parameters:
- DEPTH, 64: memory-stack entries; usable memory capacity is DEPTH-1.
- DSZ, 32: data width.
- CAP, DEPTH+1: total controller capacity (t + n + memory).
- DPW, $clog2(CAP+1): depth counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller can accept a command this cycle.
- cmd_op  in  3  ds_op_t command.
- cmd_vi  in  DSZ  literal for LIT.
- tos  out  DSZ  cached top of stack.
- nos  out  DSZ  cached next of stack.
- depth  out  DPW  total live entries.
- err_ovf  out  1  one-cycle pulse: push rejected.
- err_udf  out  1  one-cycle pulse: command rejected for insufficient depth.
- ss_op  out  2  stack_ops to the memory stack.
- ss_vi  out  DSZ  data for PUSH.
- ss_s  in  DSZ  memory-stack top; valid from the cycle after any op (NOP included).

Behaviour:
- Reset (async, rst=0): t=0, n=0, depth=0, state=IDLE, ss_op=NOP, ss_vi=0, err_ovf=0, err_udf=0. cmd_ready=1 once rst releases.
- Handshake: a command is accepted when cmd_valid && cmd_ready. All effects appear on tos/nos/depth the next cycle. ss_op is combinational during the accept cycle; it is NOP whenever nothing is accepted.
- FSM states: IDLE and ROT2.
  - cmd_ready=1 only in IDLE.
  - ROT moves IDLE->ROT2; ROT2 always returns to IDLE next cycle.
- "Spill" means ss_op=PUSH with ss_vi=n, issued only if depth>=2.
- "Fill" means n<=ss_s with ss_op=POP if depth>=3; if depth==2, n<=0 and no POP is issued.
- Command effects (stack picture a b c = mem-top n t):
  - LIT: needs depth<CAP. Spill; n<=t; t<=cmd_vi; depth+1.
  - DUP: needs 1<=depth<CAP. Spill; n<=t; depth+1.
  - OVER: needs 2<=depth<CAP. Spill; n<=t; t<=n; depth+1.
  - DROP: needs depth>=1. t<=n; fill; depth-1.
  - NIP: needs depth>=2. Fill; t unchanged; depth-1.
  - SWAP: needs depth>=2. t<=n; n<=t; no bus op.
  - ROT: needs depth>=3. Two cycles, each issuing exactly one bus op, ready low in ROT2:
    - cycle 1 (IDLE): ss_op=POP; tmp<=n; n<=t; t<=ss_s.
    - cycle 2 (ROT2): ss_op=PUSH, ss_vi=tmp.
    - depth unchanged.
  - NOP: no change.
- Depth bookkeeping: when depth==1, the "n" slot is invalid but still held. A spill with depth<2 issues no PUSH.
- Rejected commands:
  - Insufficient depth: accepted (ready stays 1), state unchanged, no bus op, err_udf=1 for one cycle.
  - Push at depth==CAP: same handling, with err_ovf=1.
- Error precedence: if a command fails both checks, err_udf wins.
- Reset mid-ROT (rst asserted in ROT2): the PUSH is abandoned, all state clears, and the stack module must be reset together with the controller.
- Arithmetic: depth is unsigned DPW bits, never wraps; the bounds checks above guarantee this.

Optional Feature:
- Macro DS_CTRL_HWM_EN.
- Defined: adds output hwm[DPW-1:0], the maximum depth reached since reset. It updates the cycle after depth exceeds it and resets to 0.
- Undefined: the port and register are absent; behaviour is otherwise identical.

Decomposition:
- Shared package forthsuper_pkg holds:
  - stack_ops (NOP=0, PUSH=1, POP=2, PICK=3), moved out of the stack file.
  - ds_op_t: NOP=0, LIT=1, DUP=2, DROP=3, SWAP=4, OVER=5, ROT=6, NIP=7.
  - the ds_state_t enum.
- No sub-module; the controller is a single module. The bench instantiates it with stack.

Test Plan:
- Reset: rst=0 mid-run -> tos=0, nos=0, depth=0, ss_op=NOP, cmd_ready=1 after release.
- LIT 1, 2, 3, 4 -> tos=4, nos=3, depth=4. Bus sees PUSH 1 on the third LIT and PUSH 2 on the fourth. Then DROP x3 -> tos=1, depth=1, two POPs observed, nos=0 after the last.
- LIT 10, 20, 30; ROT -> cmd_ready low one cycle; tos=10, nos=30, memory top 20; bus ops POP then PUSH 20.
- SWAP at depth 1 -> err_udf pulse, tos/depth unchanged, ss_op=NOP. DROP at depth 0 -> err_udf.
- Fill to depth CAP (65) with LIT, then LIT 0xDEAD -> err_ovf pulse, depth stays 65, no PUSH issued.
- DS_CTRL_HWM_EN: LIT x5, DROP x3 -> hwm=5, depth=2. Back-to-back DUP/OVER/NIP streams checked against a reference queue model.
